// File: rtl/pong_game_controller_pkg.sv
// Shared types and helpers for the Pong game controller.
// State encodings, speed-level width and BCD score increment.
package pong_game_controller_pkg;

    localparam int SPEED_W = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        MISS  = 3'd3,
        OVER  = 3'd4
    } state_t;

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'h99) begin
            result = value;
        end else if (value[3:0] == 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/pong_game_controller_debouncer.sv
// Button conditioner: 2-flop synchronizer, stability counter and
// a one-cycle pulse on the debounced rising edge.
module button_debouncer #(
    parameter int unsigned CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button,
    output logic pulse
);

    localparam int unsigned W = $clog2(CYCLES);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic         meta;
    logic         sync;
    logic         stable;
    logic [W-1:0] count;

    // Accept a new level only after it has differed for CYCLES clocks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            count  <= '0;
            pulse  <= 1'b0;
        end else begin
            meta  <= button;
            sync  <= meta;
            pulse <= 1'b0;
            if (sync == stable) begin
                count <= '0;
            end else if (count == LAST) begin
                count  <= '0;
                stable <= sync;
                pulse  <= sync;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pong_game_controller.sv
// Match sequencer for VGA Pong: serve, play, miss and game over.
// PONG_SPEEDUP_EN enables the hit counter and speed levels.
module pong_game_controller
    import pong_game_controller_pkg::*;
#(
    parameter int unsigned LIVES_INIT      = 3,
    parameter int unsigned SERVE_FRAMES    = 120,
    parameter int unsigned MISS_FRAMES     = 60,
    parameter int unsigned HITS_PER_LEVEL  = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_start_but,
    input  logic               i_frame_tick,
    input  logic               i_paddle_hit,
    input  logic               i_miss,
    output logic               o_ball_reset,
    output logic               o_ball_enable,
    output logic [SPEED_W-1:0] o_speed_level,
    output logic [7:0]         o_score,
    output logic [1:0]         o_lives,
    output logic               o_game_over,
    output logic [2:0]         o_state
);

    localparam logic [1:0] LIVES0     = 2'(LIVES_INIT);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] MISS_LAST  = 8'(MISS_FRAMES - 1);

    state_t     state;
    logic [7:0] frame_cnt;
    logic       start;

    button_debouncer #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_start (
        .clock  (i_clock),
        .reset_n(i_reset_n),
        .button (i_start_but),
        .pulse  (start)
    );

    assign o_state = state;

`ifdef PONG_SPEEDUP_EN
    localparam logic [3:0] HIT_LAST = 4'(HITS_PER_LEVEL - 1);

    logic [3:0]         hit_cnt;
    logic [SPEED_W-1:0] speed;

    assign o_speed_level = speed;

    // Count paddle hits in PLAY and raise the speed every HIT_LAST+1 hits.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hit_cnt <= '0;
            speed   <= '0;
        end else if ((state == IDLE || state == OVER) && start) begin
            hit_cnt <= '0;
            speed   <= '0;
        end else if (state == PLAY && i_paddle_hit && !i_miss) begin
            if (hit_cnt == HIT_LAST) begin
                hit_cnt <= '0;
                if (speed != 2'd3) begin
                    speed <= speed + 2'd1;
                end
            end else begin
                hit_cnt <= hit_cnt + 4'd1;
            end
        end
    end
`else
    assign o_speed_level = '0;
`endif

    // Match FSM with registered outputs set on each transition.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            frame_cnt     <= '0;
            o_score       <= '0;
            o_lives       <= LIVES0;
            o_ball_reset  <= 1'b1;
            o_ball_enable <= 1'b0;
            o_game_over   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state         <= SERVE;
                        frame_cnt     <= '0;
                        o_score       <= '0;
                        o_lives       <= LIVES0;
                        o_ball_reset  <= 1'b1;
                        o_ball_enable <= 1'b0;
                        o_game_over   <= 1'b0;
                    end
                end
                SERVE: begin
                    if (i_frame_tick) begin
                        if (frame_cnt == SERVE_LAST) begin
                            state         <= PLAY;
                            frame_cnt     <= '0;
                            o_ball_reset  <= 1'b0;
                            o_ball_enable <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                PLAY: begin
                    if (i_miss) begin
                        state         <= MISS;
                        frame_cnt     <= '0;
                        o_ball_enable <= 1'b0;
                        if (o_lives != 2'd0) begin
                            o_lives <= o_lives - 2'd1;
                        end
                    end else if (i_paddle_hit) begin
                        o_score <= bcd_inc(o_score);
                    end
                end
                MISS: begin
                    if (i_frame_tick) begin
                        if (frame_cnt == MISS_LAST) begin
                            frame_cnt    <= '0;
                            o_ball_reset <= 1'b1;
                            if (o_lives == 2'd0) begin
                                state       <= OVER;
                                o_game_over <= 1'b1;
                            end else begin
                                state <= SERVE;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    frame_cnt     <= '0;
                    o_ball_reset  <= 1'b1;
                    o_ball_enable <= 1'b0;
                    o_game_over   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_controller.sv
// Directed bench for pong_game_controller.
// Expected speed level follows PONG_SPEEDUP_EN.
module tb_pong_game_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn = 1'b0;
    logic       tick = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       ball_reset;
    logic       ball_enable;
    logic [1:0] speed;
    logic [7:0] score;
    logic [1:0] lives;
    logic       game_over;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pong_game_controller #(
        .LIVES_INIT     (3),
        .SERVE_FRAMES   (3),
        .MISS_FRAMES    (2),
        .HITS_PER_LEVEL (5),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_start_but  (btn),
        .i_frame_tick (tick),
        .i_paddle_hit (hit),
        .i_miss       (miss),
        .o_ball_reset (ball_reset),
        .o_ball_enable(ball_enable),
        .o_speed_level(speed),
        .o_score      (score),
        .o_lives      (lives),
        .o_game_over  (game_over),
        .o_state      (state)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One-cycle pulse on the chosen inputs; returns at the next negedge.
    task automatic pulse(input logic t, input logic h, input logic m);
        @(negedge clk);
        tick = t;
        hit  = h;
        miss = m;
        @(negedge clk);
        tick = 1'b0;
        hit  = 1'b0;
        miss = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0);
    endtask

    // Hold start until SERVE is reached (bounded), then release and settle.
    task automatic press_start(input string tag);
        @(negedge clk);
        btn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (state == 3'd1) break;
        end
        chk(tag, state, 3'd1);
        btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    logic [1:0] exp_speed_sat;
    logic [1:0] exp_speed_12;

    initial begin
`ifdef PONG_SPEEDUP_EN
        exp_speed_12  = 2'd2;
        exp_speed_sat = 2'd3;
`else
        exp_speed_12  = 2'd0;
        exp_speed_sat = 2'd0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_ball_reset", ball_reset, 1);
        chk("rst_enable", ball_enable, 0);
        chk("rst_speed", speed, 0);
        chk("rst_score", score, 8'h00);
        chk("rst_lives", lives, 3);
        chk("rst_game_over", game_over, 0);
        chk("rst_state", state, 0);
        rst_n = 1'b1;

        // Bouncy press shorter than the debounce window.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); btn = 1'b1;
            repeat (2) @(negedge clk);
            btn = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("bounce_state", state, 0);

        press_start("start_serve");
        chk("start_lives", lives, 3);
        chk("start_score", score, 8'h00);

        // Hits and frame ticks in SERVE are ignored for the score.
        pulse(1'b0, 1'b1, 1'b0);
        chk("serve_hit_ignored", score, 8'h00);

        ticks(2);
        chk("serve_after2", state, 1);
        ticks(1);
        chk("play_state", state, 2);
        chk("play_enable", ball_enable, 1);
        chk("play_ball_reset", ball_reset, 0);

        for (int i = 1; i <= 12; i++) begin
            pulse(1'b0, 1'b1, 1'b0);
            if (i == 9) chk("score_09", score, 8'h09);
            if (i == 10) chk("score_10", score, 8'h10);
        end
        chk("score_12", score, 8'h12);
        chk("speed_12", speed, exp_speed_12);

        for (int i = 0; i < 87; i++) pulse(1'b0, 1'b1, 1'b0);
        chk("score_99", score, 8'h99);
        pulse(1'b0, 1'b1, 1'b0);
        chk("score_sat", score, 8'h99);
        chk("speed_sat", speed, exp_speed_sat);

        pulse(1'b0, 1'b1, 1'b1);
        chk("hitmiss_score", score, 8'h99);
        chk("hitmiss_lives", lives, 2);
        chk("hitmiss_state", state, 3);
        chk("miss_enable", ball_enable, 0);
        chk("miss_ball_reset", ball_reset, 0);
        ticks(1);
        chk("miss_hold", state, 3);
        ticks(1);
        chk("miss_to_serve", state, 1);
        chk("speed_kept", speed, exp_speed_sat);

        ticks(3);
        pulse(1'b0, 1'b0, 1'b1);
        chk("miss2_lives", lives, 1);
        ticks(2);
        ticks(3);
        pulse(1'b0, 1'b0, 1'b1);
        chk("miss3_lives", lives, 0);
        ticks(2);
        chk("over_state", state, 4);
        chk("over_flag", game_over, 1);
        chk("over_ball_reset", ball_reset, 1);

        press_start("restart_serve");
        chk("restart_lives", lives, 3);
        chk("restart_score", score, 8'h00);
        chk("restart_speed", speed, 0);
        chk("restart_over", game_over, 0);

        ticks(1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_state", state, 0);
        chk("midrst_lives", lives, 3);
        chk("midrst_ball_reset", ball_reset, 1);
        chk("midrst_enable", ball_enable, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(3);
        chk("after_rst_idle", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pong_game_controller.md
# pong_game_controller

Game-level sequencer for the VGA Pong design. It owns the match flow: idle, serve, play, miss and game over. It gates ball motion in the pixel generator, keeps a BCD score, lives and a speed level, and debounces the start button. It sits between the board buttons / VGA sync handler and the pixel generator, and advances only on frame ticks and pixel-generator event pulses.

## Interface
Parameters:
- LIVES_INIT, 3: lives at match start (1..3).
- SERVE_FRAMES, 120: frame ticks the ball is held at the serve position (1..255).
- MISS_FRAMES, 60: frame ticks the board freezes after a miss (1..255).
- HITS_PER_LEVEL, 5: paddle hits per speed-level increment (1..15).
- DEBOUNCE_CYCLES, 1000000: clock cycles the start button must be stable (10 ms at 100 MHz, ≥2).

Ports:
- i_clock, in, 1: 100 MHz system clock; single clock domain.
- i_reset_n, in, 1: reset, asynchronous assert, active-low.
- i_start_but, in, 1: raw, asynchronous start button.
- i_frame_tick, in, 1: one-cycle pulse once per frame (end of visible area).
- i_paddle_hit, in, 1: one-cycle pulse from the pixel generator on a ball/paddle contact.
- i_miss, in, 1: one-cycle pulse from the pixel generator when the ball passes the right edge.
- o_ball_reset, out, 1: hold the ball at the serve position.
- o_ball_enable, out, 1: ball position and paddle may update on frame ticks.
- o_speed_level, out, 2: ball speed selector, 0..3.
- o_score, out, 8: two BCD digits, [7:4] tens and [3:0] units.
- o_lives, out, 2: remaining lives.
- o_game_over, out, 1: high in the OVER state.
- o_state, out, 3: current state encoding, for debug.

## Operation
- The start button passes through a 2-flop synchronizer and then a debouncer. The start event is a one-cycle pulse on the debounced rising edge.
- States:
  - IDLE=0: ball_reset=1, enable=0. On a start event, go to SERVE and initialise the match.
  - SERVE=1: ball_reset=1, enable=0. The frame counter increments on each i_frame_tick. On the tick where counter==SERVE_FRAMES-1, go to PLAY and clear the counter.
  - PLAY=2: ball_reset=0, enable=1.
    - i_paddle_hit: score +1 in BCD (09→10, 99 saturates). The hit counter increments.
    - When the hit counter reaches HITS_PER_LEVEL, clear it and increment speed_level, saturating at 3.
    - i_miss: lives −1, go to MISS and clear the frame counter.
  - MISS=3: ball_reset=0, enable=0 (ball frozen where it left). Count frame ticks. On the tick where counter==MISS_FRAMES-1, go to OVER if lives==0, else go to SERVE. speed_level is kept.
  - OVER=4: game_over=1, ball_reset=1, enable=0. On a start event, go to SERVE and initialise the match.
- Match initialise: score=0, lives=LIVES_INIT, speed_level=0, hit counter=0, frame counter=0.
- Event filtering:
  - Events arriving outside their state are ignored: paddle_hit or miss outside PLAY, start outside IDLE/OVER.
  - Simultaneous paddle_hit and miss in PLAY: the miss wins. Score and hit counter are unchanged.
  - A frame tick coinciding with an event is handled independently; a tick does nothing in PLAY.
- Lives never underflow: miss decrements from ≥1 only, and PLAY is unreachable with 0 lives.

## Timing
- All outputs are registered.
- Reset values: o_ball_reset=1, o_ball_enable=0, o_speed_level=0, o_score=8'h00, o_lives=LIVES_INIT, o_game_over=0, o_state=IDLE. All internal counters are 0.
- An input event in cycle N produces the state and output change in cycle N+1.
- Start latency: the raw button must be stable for DEBOUNCE_CYCLES after 2 synchronizer cycles. The start pulse follows, and the state changes one cycle after that.
- SERVE lasts exactly SERVE_FRAMES frame ticks; MISS lasts exactly MISS_FRAMES frame ticks.
- Asserting i_reset_n low at any point returns every register to its reset value immediately. The first event is accepted on the cycle after deassertion.
- The debouncer counter is width-sized from DEBOUNCE_CYCLES (clog2). Frame and hit counters are 8 and 4 bits.

## Configuration
- PONG_SPEEDUP_EN:
  - Defined: the hit counter and speed-level logic are present as described.
  - Undefined: the hit counter is not built, o_speed_level is tied to 2'd0, and HITS_PER_LEVEL is unused.

## Structure
- Shared package/header: state encodings (IDLE..OVER), the BCD increment-with-saturate function, and the 2-bit speed-level width.
- One sub-module, button_debouncer (synchronizer, stability counter, rising-edge pulse). It is reused later for the paddle buttons.

## Test plan
- Reset then start pressed with DEBOUNCE_CYCLES=4, button bounces under 4 cycles: no start. Clean press: IDLE→SERVE, lives=3, score=00.
- SERVE_FRAMES=3: exactly 3 frame ticks, then o_state=PLAY, o_ball_enable=1 one cycle after the third tick.
- In PLAY, 12 paddle_hit pulses with HITS_PER_LEVEL=5: o_score=8'h12, speed_level=2. With the macro undefined, speed_level stays 0.
- Score at 8'h99 plus one hit: it stays 8'h99. Score 8'h09 plus one hit gives 8'h10.
- paddle_hit and miss in the same cycle: score unchanged, lives 3→2, state MISS. After MISS_FRAMES ticks the state is SERVE.
- Three misses: after the last MISS interval the state is OVER with game_over=1. Reset asserted mid-SERVE returns all outputs to reset values immediately.
